// File: rtl/udma_chmap_ctrl.sv
// Runtime-programmable uDMA channel-to-peripheral map: software writes a shadow table,
// and a commit checks it for conflicts, drains the changed channels, then swaps it active.
module udma_chmap_ctrl #(
    parameter int N_CH       = 8,
    parameter int N_PERIPHS  = 8,
    parameter int DRAIN_TO   = 1024,
    localparam int ID_W      = (N_PERIPHS > 1) ? $clog2(N_PERIPHS) : 1,
    localparam int CFG_AW    = $clog2(N_CH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_req_i,
    input  logic                   cfg_we_i,
    input  logic [CFG_AW-1:0]      cfg_addr_i,
    input  logic [31:0]            cfg_wdata_i,
    output logic                   cfg_gnt_o,
    output logic                   cfg_rvalid_o,
    output logic [31:0]            cfg_rdata_o,
    input  logic [N_CH-1:0]        ch_busy_i,
    output logic [N_CH-1:0]        ch_hold_o,
    output logic [N_CH-1:0]        ch_en_o,
    output logic [N_CH*ID_W-1:0]   ch_per_id_o,
    output logic                   commit_done_o,
    output logic                   commit_err_o
);

    localparam int CNT_W = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DRAIN, S_SWAP} state_t;

    state_t             state_q, state_d;
    logic [N_CH-1:0]    act_en, shd_en;
    logic [ID_W-1:0]    act_id [N_CH];
    logic [ID_W-1:0]    shd_id [N_CH];
    logic [N_CH-1:0]    changed_q, changed_c;
    logic [CNT_W-1:0]   drain_cnt;
    logic               err_sticky, done_sticky;
    logic               is_entry, is_ctrl, wr_en, rd_en, ctrl_wr, commit_req;
    logic               conflict, drained, timeout, err_evt, done_evt;
    logic [31:0]        rd_mux;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata_i;

    // Shadow-entry writes stall while a commit is in flight so the checked table cannot move.
    always_comb begin
        is_entry   = (cfg_addr_i < CFG_AW'(N_CH));
        is_ctrl    = (cfg_addr_i == CFG_AW'(N_CH));
        cfg_gnt_o  = cfg_req_i && !(cfg_we_i && is_entry && (state_q != S_IDLE));
        wr_en      = cfg_gnt_o && cfg_we_i;
        rd_en      = cfg_gnt_o && !cfg_we_i;
        ctrl_wr    = wr_en && is_ctrl;
        commit_req = ctrl_wr && cfg_wdata_i[0] && (state_q == S_IDLE);
    end

    always_comb begin
        conflict  = 1'b0;
        changed_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (shd_en[i] && (32'(shd_id[i]) >= N_PERIPHS))
                conflict = 1'b1;
            for (int j = i + 1; j < N_CH; j++) begin
                if (shd_en[i] && shd_en[j] && (shd_id[i] == shd_id[j]))
                    conflict = 1'b1;
            end
            changed_c[i] = (shd_en[i] != act_en[i]) || (shd_id[i] != act_id[i]);
        end
    end

    always_comb begin
        drained = ((ch_busy_i & changed_q) == '0);
        timeout = (DRAIN_TO != 0) && (32'(drain_cnt) == DRAIN_TO - 1);
    end

    always_comb begin
        state_d  = state_q;
        err_evt  = 1'b0;
        done_evt = 1'b0;
        case (state_q)
            S_IDLE:  if (commit_req) state_d = S_CHECK;
            S_CHECK: begin
                if (conflict) begin
                    state_d = S_IDLE;
                    err_evt = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_d = S_SWAP;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_evt = 1'b1;
                end
            end
            S_SWAP: begin
                state_d  = S_IDLE;
                done_evt = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Control path: holds, drain counter, pulses, sticky status and registered read port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            changed_q     <= '0;
            ch_hold_o     <= '0;
            drain_cnt     <= '0;
            commit_err_o  <= 1'b0;
            commit_done_o <= 1'b0;
            err_sticky    <= 1'b0;
            done_sticky   <= 1'b0;
            cfg_rvalid_o  <= 1'b0;
            cfg_rdata_o   <= '0;
        end else begin
            case (state_q)
                S_CHECK: begin
                    if (!conflict) begin
                        changed_q <= changed_c;
                        ch_hold_o <= changed_c;
                    end
                end
                S_DRAIN: if (state_d == S_IDLE) ch_hold_o <= '0;
                S_SWAP:  ch_hold_o <= '0;
                default: ;
            endcase
            drain_cnt     <= (state_q == S_DRAIN) ? drain_cnt + CNT_W'(1) : '0;
            commit_err_o  <= err_evt;
            commit_done_o <= done_evt;
            err_sticky    <= err_evt  || (err_sticky  && !(ctrl_wr && cfg_wdata_i[1]));
            done_sticky   <= done_evt || (done_sticky && !(ctrl_wr && cfg_wdata_i[2]));
            cfg_rvalid_o  <= rd_en;
            cfg_rdata_o   <= rd_en ? rd_mux : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_en <= '0;
            shd_en <= '0;
            for (int k = 0; k < N_CH; k++) begin
                act_id[k] <= ID_W'(k % N_PERIPHS);
                shd_id[k] <= ID_W'(k % N_PERIPHS);
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (wr_en && (cfg_addr_i == CFG_AW'(k))) begin
                    shd_en[k] <= cfg_wdata_i[31];
                    shd_id[k] <= cfg_wdata_i[ID_W-1:0];
                end
            end
            if (state_q == S_SWAP) begin
                act_en <= shd_en;
                for (int k = 0; k < N_CH; k++) act_id[k] <= shd_id[k];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cfg_addr_i == CFG_AW'(k)) begin
                rd_mux[31]       = shd_en[k];
                rd_mux[ID_W-1:0] = shd_id[k];
            end
        end
        if (is_ctrl) rd_mux[2:0] = {done_sticky, err_sticky, state_q != S_IDLE};
    end

    always_comb begin
        ch_en_o     = act_en;
        ch_per_id_o = '0;
        for (int k = 0; k < N_CH; k++) ch_per_id_o[k*ID_W +: ID_W] = act_id[k];
    end

endmodule

// File: tb/tb_udma_chmap_ctrl.sv
// Directed bench for udma_chmap_ctrl: instance a uses the default drain timeout,
// instance b uses a 16-cycle timeout; both share the config bus, selected by sel_b.
module tb_udma_chmap_ctrl;

    logic        clk = 1'b0;
    logic        rst, req, we, sel_b;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  busy_a, busy_b;

    logic        gnt_a, gnt_b, rvalid_a, rvalid_b, done_a, done_b, err_a, err_b;
    logic [31:0] rdata_a, rdata_b;
    logic [7:0]  hold_a, hold_b, en_a, en_b;
    logic [23:0] id_a, id_b;
    logic        gnt, rvalid;
    logic [31:0] rdata;

    int          vec = 0;
    int          miss = 0;
    logic [2:0]  exp_id [8];
    logic [7:0]  hold_seen;
    logic        hold_clr = 1'b0;
    logic        ok;
    logic [31:0] rd;

    always #5 clk = ~clk;

    assign gnt    = sel_b ? gnt_b    : gnt_a;
    assign rvalid = sel_b ? rvalid_b : rvalid_a;
    assign rdata  = sel_b ? rdata_b  : rdata_a;

    udma_chmap_ctrl dut_a (
        .clk_i(clk), .rst_i(rst), .cfg_req_i(req && !sel_b), .cfg_we_i(we),
        .cfg_addr_i(addr), .cfg_wdata_i(wdata), .cfg_gnt_o(gnt_a),
        .cfg_rvalid_o(rvalid_a), .cfg_rdata_o(rdata_a), .ch_busy_i(busy_a),
        .ch_hold_o(hold_a), .ch_en_o(en_a), .ch_per_id_o(id_a),
        .commit_done_o(done_a), .commit_err_o(err_a)
    );

    udma_chmap_ctrl #(.DRAIN_TO(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .cfg_req_i(req && sel_b), .cfg_we_i(we),
        .cfg_addr_i(addr), .cfg_wdata_i(wdata), .cfg_gnt_o(gnt_b),
        .cfg_rvalid_o(rvalid_b), .cfg_rdata_o(rdata_b), .ch_busy_i(busy_b),
        .ch_hold_o(hold_b), .ch_en_o(en_b), .ch_per_id_o(id_b),
        .commit_done_o(done_b), .commit_err_o(err_b)
    );

    always @(negedge clk) begin
        if (hold_clr) hold_seen <= '0;
        else          hold_seen <= hold_seen | hold_a;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_hold_seen();
        hold_clr = 1'b1;
        tick();
        hold_clr = 1'b0;
    endtask

    function automatic logic [23:0] exp_pack();
        logic [23:0] v = '0;
        for (int k = 0; k < 8; k++) v[k*3 +: 3] = exp_id[k];
        return v;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 8; k++) exp_id[k] = 3'(k);
    endtask

    // Returns one cycle after the granting edge, with req dropped.
    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        #1;
        while (!gnt && n < 64) begin
            tick();
            n++;
        end
        chk("wr_gnt", {31'b0, gnt}, 32'd1);
        tick();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        tick();
        req = 1'b0;
        chk("rd_valid", {31'b0, rvalid}, 32'd1);
        d = rdata;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; sel_b = 1'b0; addr = '0; wdata = '0;
        busy_a = '0; busy_b = '0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_en", en_a, 0);
        chk("rst_id", id_a, exp_pack());
        chk("rst_id_lit", id_a, 32'hFAC688);
        chk("rst_hold", hold_a, 0);
        chk("rst_pulses", {done_a, err_a, done_b, err_b}, 0);
        cfg_read(4'd8, rd);  chk("rst_status", rd, 0);
        cfg_read(4'd3, rd);  chk("rst_entry3", rd, 32'h3);

        // Unmapped address: granted, dropped, reads zero
        cfg_write(4'd12, 32'hFFFF_FFFF);
        cfg_read(4'd12, rd); chk("unmapped_rd", rd, 0);
        cfg_read(4'd8, rd);  chk("unmapped_no_side", rd, 0);

        // Basic commit with idle channels
        clr_hold_seen();
        cfg_write(4'd2, 32'h8000_0005);
        cfg_write(4'd5, 32'h8000_0003);
        cfg_read(4'd2, rd);  chk("shadow_rb", rd, 32'h8000_0005);
        cfg_write(4'd8, 32'h1);
        chk("check_hold", hold_a, 0);
        tick(); chk("drain_hold", hold_a, 8'h24);
        tick(); chk("swap_hold", hold_a, 8'h24);
        chk("swap_en_old", en_a, 0);
        tick();
        exp_id[2] = 3'd5; exp_id[5] = 3'd3;
        chk("commit_en", en_a, 8'h24);
        chk("commit_id", id_a, exp_pack());
        chk("commit_done", {done_a, err_a}, 2'b10);
        chk("commit_hold_clr", hold_a, 0);
        tick(); chk("done_one_cycle", done_a, 0);
        chk("hold_only_changed", hold_seen, 8'h24);
        cfg_read(4'd8, rd);  chk("status_done", rd, 32'h4);
        cfg_write(4'd8, 32'h4);
        cfg_read(4'd8, rd);  chk("status_done_clr", rd, 0);

        // Duplicate per_id conflict
        clr_hold_seen();
        cfg_write(4'd1, 32'h8000_0006);
        cfg_write(4'd4, 32'h8000_0006);
        cfg_write(4'd8, 32'h1);
        tick();
        chk("conflict_err", {done_a, err_a}, 2'b01);
        chk("conflict_en", en_a, 8'h24);
        chk("conflict_id", id_a, exp_pack());
        cfg_read(4'd8, rd);  chk("status_err", rd, 32'h2);
        chk("conflict_no_hold", hold_seen, 0);
        cfg_write(4'd8, 32'h2);
        cfg_write(4'd1, 32'h1);
        cfg_write(4'd4, 32'h4);

        // Busy changed channel stretches drain; shadow write stalls meanwhile
        clr_hold_seen();
        cfg_write(4'd3, 32'h8000_0007);
        busy_a = 8'h08;
        cfg_write(4'd8, 32'h1);
        tick(); chk("busy_hold_first", hold_a, 8'h08);
        req = 1'b1; we = 1'b1; addr = 4'd0; wdata = 32'h8000_0001;
        #1;
        chk("drain_stall", gnt, 0);
        ok = 1'b1;
        repeat (19) begin
            tick();
            if (hold_a !== 8'h08 || gnt !== 1'b0 || done_a !== 1'b0) ok = 1'b0;
        end
        chk("busy_hold_20", ok, 1);
        busy_a = 8'h00;
        tick();
        chk("swap_hold_b", hold_a, 8'h08);
        chk("swap_stall", gnt, 0);
        chk("swap_en_pre", en_a, 8'h24);
        tick();
        exp_id[3] = 3'd7;
        chk("busy_en", en_a, 8'h2C);
        chk("busy_id", id_a, exp_pack());
        chk("busy_done", done_a, 1);
        chk("busy_hold_clr", hold_a, 0);
        chk("stall_release", gnt, 1);
        tick();
        req = 1'b0; we = 1'b0;
        cfg_read(4'd0, rd);  chk("stalled_wr_landed", rd, 32'h8000_0001);
        chk("busy_hold_only3", hold_seen, 8'h08);

        // Reset during DRAIN
        cfg_write(4'd6, 32'h8000_0000);
        busy_a = 8'h40;
        cfg_write(4'd8, 32'h1);
        tick(); chk("pre_rst_hold", hold_a, 8'h41);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy_a = 8'h00;
        reset_model();
        chk("rst_mid_hold", hold_a, 0);
        chk("rst_mid_en", en_a, 0);
        chk("rst_mid_id", id_a, exp_pack());
        chk("rst_mid_pulse", {done_a, err_a}, 0);
        tick(); chk("rst_mid_no_pulse", {done_a, err_a}, 0);
        cfg_read(4'd8, rd);  chk("rst_mid_status", rd, 0);
        cfg_read(4'd2, rd);  chk("rst_mid_shadow", rd, 32'h2);

        // Drain timeout on instance b
        sel_b = 1'b1;
        busy_b = 8'h08;
        cfg_write(4'd3, 32'h8000_0007);
        cfg_write(4'd8, 32'h1);
        tick(); chk("to_hold_first", hold_b, 8'h08);
        ok = 1'b1;
        repeat (15) begin
            tick();
            if (hold_b !== 8'h08 || err_b !== 1'b0) ok = 1'b0;
        end
        chk("to_hold_16", ok, 1);
        tick();
        chk("to_err", {done_b, err_b}, 2'b01);
        chk("to_hold_clr", hold_b, 0);
        chk("to_en", en_b, 0);
        chk("to_id", id_b, exp_pack());
        busy_b = 8'h00;
        cfg_read(4'd8, rd);  chk("to_status", rd, 32'h2);
        sel_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/udma_chmap_ctrl.md
Name: udma_chmap_ctrl

Overview:
Runtime-programmable channel-to-peripheral map for the uDMA subsystem. It replaces the fixed, elaboration-time channel ID assignment with a table that software programs through a register port. A shadow table is written by software. A commit sequence checks the shadow table for conflicts, drains the affected channels, and then swaps the shadow table into the active table. The active table drives the channel routing muxes in the uDMA core.

Parameters:
N_CH, 8, number of logical linear channels mapped
N_PERIPHS, 8, number of peripheral IDs addressable
ID_W, $clog2(N_PERIPHS) (min 1), width of a peripheral ID (derived, not overridden)
DRAIN_TO, 1024, drain timeout in cycles; 0 disables the timeout
CFG_AW, $clog2(N_CH+1), config address width (derived)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cfg_req_i  in  1  config access request
cfg_we_i  in  1  1 = write, 0 = read
cfg_addr_i  in  CFG_AW  word index: 0..N_CH-1 = shadow entries, N_CH = CTRL/STATUS
cfg_wdata_i  in  32  write data
cfg_gnt_o  out  1  access accepted this cycle
cfg_rvalid_o  out  1  read data valid (one cycle after a granted read)
cfg_rdata_o  out  32  read data
ch_busy_i  in  N_CH  per-channel transfer in flight
ch_hold_o  out  N_CH  channel must not start a new transfer
ch_en_o  out  N_CH  active table enable bits
ch_per_id_o  out  N_CH*ID_W  active peripheral IDs; channel k occupies [k*ID_W +: ID_W]
commit_done_o  out  1  one-cycle pulse: swap completed
commit_err_o  out  1  one-cycle pulse: commit rejected or drain timed out

Behaviour:
- Reset is synchronous and active-high; the clock is clk_i.
- Reset values:
  - Active and shadow entries: en=0, per_id = k mod N_PERIPHS.
  - State IDLE; all outputs 0; sticky status bits 0.
- Entry format: bit31 = en, bits[ID_W-1:0] = per_id. Other bits read 0 and are ignored on write.
- Writes with per_id >= N_PERIPHS are stored and are flagged as a conflict at CHECK.
- CTRL write bits:
  - bit0 COMMIT: write-1 starts a commit; ignored unless the state is IDLE.
  - bit1: write-1-to-clear ERR.
  - bit2: write-1-to-clear DONE.
- STATUS read bits: bit0 BUSY (state != IDLE), bit1 ERR (sticky), bit2 DONE (sticky).
- Addresses above N_CH: reads return 0, writes are dropped, the access is still granted.
- Grant:
  - cfg_gnt_o = cfg_req_i, except writes to shadow entries while state != IDLE, which are stalled (gnt=0) until IDLE.
  - Reads are never stalled.
  - Read data is registered: rvalid and rdata appear the cycle after gnt.
- FSM IDLE -> CHECK -> DRAIN -> SWAP -> IDLE:
  - IDLE: a granted COMMIT write moves to CHECK on the next edge.
  - CHECK (1 cycle):
    - Conflict = any enabled shadow entry with per_id >= N_PERIPHS, or two enabled shadow entries with equal per_id.
    - On conflict: go to IDLE, pulse commit_err_o in the cycle after, set ERR, leave the active table unchanged.
    - Otherwise: latch changed[k] = (shadow[k] != active[k]) and go to DRAIN.
  - DRAIN:
    - ch_hold_o = changed (registered; asserted from the first DRAIN cycle).
    - When (ch_busy_i & changed) == 0, go to SWAP.
    - A drain counter increments each cycle. If DRAIN_TO != 0 and the counter reaches DRAIN_TO: clear holds, go to IDLE, pulse err, set ERR, leave the active table unchanged.
  - SWAP (1 cycle):
    - active <= shadow, clear ch_hold_o, go to IDLE.
    - commit_done_o pulses and DONE is set in the cycle after SWAP.
- Minimum commit latency: COMMIT granted at edge E0 → CHECK after E0 → DRAIN after E1 → SWAP after E2 → active table updated at E3 and commit_done_o high in the cycle after E3.
- A commit with no changed entries still walks all states and reports done.
- Unchanged channels are never held.
- ch_busy_i rising on a changed channel during DRAIN (a transfer already in the start pipeline) only extends the drain.
- Setting and clearing a sticky bit in the same cycle: set wins.
- Reset mid-commit returns to IDLE, drops the holds, and restores the reset tables; no pulse is produced.

Test Plan:
- Reset → ch_en_o=0, ch_per_id_o = {7,6,...,0} for N_CH=8/N_PERIPHS=8, ch_hold_o=0, STATUS=0.
- Program entry 2 = 0x8000_0005 and entry 5 = 0x8000_0003, then COMMIT with ch_busy_i=0 → active entries updated at E3, done pulse, STATUS=0x4, hold never asserted on channels other than 2 and 5.
- Entries 1 and 4 both enabled with per_id 6, then COMMIT → err pulse after CHECK, STATUS=0x2, active table unchanged, ch_hold_o never asserted.
- Change channel 3 while ch_busy_i[3]=1 for 20 cycles → ch_hold_o[3]=1 from the first DRAIN cycle for 20+ cycles, swap one cycle after busy drops, shadow write during DRAIN sees gnt=0 until IDLE.
- DRAIN_TO=16 with ch_busy_i stuck on a changed channel → err pulse after 16 DRAIN cycles, holds released, active table unchanged, BUSY=0.
- Assert rst_i during DRAIN → next cycle: IDLE, holds=0, no done/err pulse, reset table values restored.
